// File: rtl/arb_request_buffer.sv
// rtl/arb_request_buffer.sv - four-channel flit buffer feeding a combinational arbiter
// Per-channel FIFOs raise requests; the granted channel is popped into a registered output slot.
module arb_request_buffer #(
    parameter int FLIT_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          in_valid,
    input  logic [4*FLIT_W-1:0] in_flit,
    output logic [3:0]          in_ready,
    output logic [3:0]          requests,
    input  logic [1:0]          granted,
    output logic                out_valid,
    output logic [FLIT_W-1:0]   out_flit,
    output logic [1:0]          out_src,
    input  logic                out_ready
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FLIT_W-1:0] mem_q [4][DEPTH];
    logic [FLIT_W-1:0] mem_d [4][DEPTH];
    logic [PTR_W-1:0]  wptr_q [4];
    logic [PTR_W-1:0]  wptr_d [4];
    logic [PTR_W-1:0]  rptr_q [4];
    logic [PTR_W-1:0]  rptr_d [4];
    logic [CNT_W-1:0]  cnt_q  [4];
    logic [CNT_W-1:0]  cnt_d  [4];

    logic              out_valid_q, out_valid_d;
    logic [FLIT_W-1:0] out_flit_q, out_flit_d;
    logic [1:0]        out_src_q, out_src_d;

    logic [3:0] push;
    logic [3:0] pop;
    logic       grant_ok;
    logic       load;

    // Ready and request come from registered counts only, so no input-to-output paths exist.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_ready[i] = (cnt_q[i] < CNT_W'(DEPTH));
            requests[i] = (cnt_q[i] != '0);
        end
    end

    // The arbiter's index is meaningless when its selected channel is empty.
    assign grant_ok = requests[granted];
    assign load     = grant_ok & (~out_valid_q | out_ready);

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < 4; i++) begin
            push[i]   = in_valid[i] & in_ready[i];
            pop[i]    = load & (granted == 2'(i));
            wptr_d[i] = push[i] ? wptr_q[i] + PTR_W'(1) : wptr_q[i];
            rptr_d[i] = pop[i] ? rptr_q[i] + PTR_W'(1) : rptr_q[i];
            cnt_d[i]  = cnt_q[i];
            if (push[i] && !pop[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!push[i] && pop[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (push[i]) begin
                mem_d[i][wptr_q[i]] = in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_src_d   = out_src_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_flit_d  = mem_q[granted][rptr_q[granted]];
            out_src_d   = granted;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_src_q   <= 2'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_src_q   <= out_src_d;
        end
    end

    // Storage is qualified by the counts, so it needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid = out_valid_q;
    assign out_flit  = out_flit_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_request_buffer.sv
// tb/tb_arb_request_buffer.sv - randomized self-checking bench against a queue-based model
module tb_arb_request_buffer;

    localparam int FLIT_W = 64;
    localparam int DEPTH  = 2;

    logic              clk;
    logic              reset;
    logic [3:0]        in_valid;
    logic [4*FLIT_W-1:0] in_flit;
    logic [3:0]        in_ready;
    logic [3:0]        requests;
    logic [1:0]        granted;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic [1:0]        out_src;
    logic              out_ready;

    arb_request_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_flit   (in_flit),
        .in_ready  (in_ready),
        .requests  (requests),
        .granted   (granted),
        .out_valid (out_valid),
        .out_flit  (out_flit),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [63:0] mq [4][$];
    logic        m_ov;
    logic [63:0] m_of;
    logic [1:0]  m_os;
    logic [1:0]  rr_last;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        m_ov = 1'b0;
        m_of = '0;
        m_os = 2'd0;
    endtask

    function automatic logic [3:0] model_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [3:0] model_rdy();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (mq[i].size() < DEPTH);
        return r;
    endfunction

    // Round-robin stand-in for the arbiter: first requester after the last winner.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = last + 2'(k);
            if (req[c]) return c;
        end
        return last;
    endfunction

    task automatic model_step();
        logic [3:0] rdy;
        logic [3:0] req;
        rdy = model_rdy();
        req = model_req();
        if (req[granted] && (!m_ov || out_ready)) begin
            m_of = mq[granted].pop_front();
            m_ov = 1'b1;
            m_os = granted;
        end else if (m_ov && out_ready) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i] && rdy[i]) mq[i].push_back(in_flit[i*FLIT_W +: FLIT_W]);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".requests"}, 64'(requests), 64'(model_req()));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(model_rdy()));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        check({tag, ".out_flit"}, out_flit, m_of);
        check({tag, ".out_src"}, 64'(out_src), 64'(m_os));
    endtask

    task automatic cycle(input string tag, input logic [3:0] iv, input logic [4*FLIT_W-1:0] fl,
                         input logic ordy, input logic [1:0] g);
        in_valid  = iv;
        in_flit   = fl;
        out_ready = ordy;
        granted   = g;
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all(tag);
    endtask

    function automatic logic [4*FLIT_W-1:0] one_flit(input int ch, input logic [63:0] v);
        logic [4*FLIT_W-1:0] f;
        f = '0;
        f[ch*FLIT_W +: FLIT_W] = v;
        return f;
    endfunction

    initial begin
        logic [4*FLIT_W-1:0] fl;
        logic [3:0]          req;
        logic [1:0]          g;

        reset     = 1'b1;
        in_valid  = '0;
        in_flit   = '0;
        out_ready = 1'b0;
        granted   = 2'd0;
        rr_last   = 2'd3;
        model_reset();

        @(negedge clk);
        compare_all("rst_hold");
        check("rst_req_const", 64'(requests), 64'h0);
        check("rst_rdy_const", 64'(in_ready), 64'hF);
        reset = 1'b0;

        // Idle: a stray grant with nothing requested must not load.
        cycle("idle0", 4'b0000, '0, 1'b1, 2'd3);
        cycle("idle1", 4'b0000, '0, 1'b1, 2'd3);
        check("idle_ov", 64'(out_valid), 64'h0);

        // Single flit on channel 2.
        cycle("t2_push", 4'b0100, one_flit(2, 64'hA5A5), 1'b1, 2'd3);
        check("t2_req_n1", 64'(requests), 64'h4);
        cycle("t2_pop", 4'b0000, '0, 1'b1, 2'd2);
        check("t2_ov", 64'(out_valid), 64'h1);
        check("t2_flit", out_flit, 64'hA5A5);
        check("t2_src", 64'(out_src), 64'h2);
        check("t2_req_n2", 64'(requests), 64'h0);
        cycle("t2_drain", 4'b0000, '0, 1'b1, 2'd2);

        // Fill channel 0 under backpressure, stall, then drain in order.
        cycle("t3_p1", 4'b0001, one_flit(0, 64'h11), 1'b0, 2'd0);
        cycle("t3_p2", 4'b0001, one_flit(0, 64'h22), 1'b0, 2'd0);
        cycle("t3_p3", 4'b0001, one_flit(0, 64'h33), 1'b0, 2'd0);
        check("t3_full", 64'(in_ready[0]), 64'h0);
        cycle("t3_blocked", 4'b0001, one_flit(0, 64'h44), 1'b0, 2'd0);
        for (int k = 0; k < 3; k++) cycle("t5_stall", 4'b0000, '0, 1'b0, 2'd0);
        check("t5_flit", out_flit, 64'h11);
        cycle("t3_d1", 4'b0000, '0, 1'b1, 2'd0);
        check("t3_d1_flit", out_flit, 64'h22);
        check("t3_d1_rdy", 64'(in_ready[0]), 64'h1);
        cycle("t3_d2", 4'b0000, '0, 1'b1, 2'd0);
        check("t3_d2_flit", out_flit, 64'h33);
        cycle("t3_d3", 4'b0000, '0, 1'b1, 2'd0);

        // One flit per channel, drained through the round-robin arbiter.
        fl = one_flit(0, 64'd1) | one_flit(1, 64'd2) | one_flit(2, 64'd3) | one_flit(3, 64'd4);
        cycle("t4_load", 4'b1111, fl, 1'b1, 2'd0);
        for (int k = 0; k < 4; k++) begin
            g = rr_pick(model_req(), rr_last);
            rr_last = g;
            cycle("t4_drain", 4'b0000, '0, 1'b1, g);
            check("t4_val_src", out_flit, 64'(out_src) + 64'd1);
        end
        check("t4_req_empty", 64'(requests), 64'h0);
        cycle("t4_idle", 4'b0000, '0, 1'b1, 2'd0);

        // Reset in the middle of traffic on channels 1 and 3.
        fl = one_flit(1, 64'h101) | one_flit(3, 64'h301);
        cycle("t6_a", 4'b1010, fl, 1'b0, 2'd1);
        fl = one_flit(1, 64'h102) | one_flit(3, 64'h302);
        cycle("t6_b", 4'b1010, fl, 1'b0, 2'd1);
        cycle("t6_c", 4'b0010, one_flit(1, 64'h103), 1'b0, 2'd1);
        check("t6_pre_ov", 64'(out_valid), 64'h1);
        in_valid = '0;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_ov", 64'(out_valid), 64'h0);
        check("t6_async_req", 64'(requests), 64'h0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        compare_all("t6_after");
        cycle("t6_push", 4'b0010, one_flit(1, 64'hBEEF), 1'b1, 2'd0);
        cycle("t6_pop", 4'b0000, '0, 1'b1, 2'd1);
        check("t6_first_out", out_flit, 64'hBEEF);

        // Randomized traffic, including grants that point at empty channels.
        for (int n = 0; n < 600; n++) begin
            for (int w = 0; w < 8; w++) fl[w*32 +: 32] = $urandom;
            req = model_req();
            if (req != 4'b0000 && $urandom_range(0, 9) < 8) begin
                g = rr_pick(req, rr_last);
                rr_last = g;
            end else begin
                g = 2'($urandom_range(0, 3));
            end
            cycle("rand", 4'($urandom_range(0, 15)), fl, ($urandom_range(0, 9) < 6), g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_request_buffer.md
Name: arb_request_buffer

Overview:
- Requester-side partner of the combinational four_way_arbiter.
- Buffers flits from four input channels and drives the 4-bit `requests` vector into the arbiter.
- Consumes the arbiter's 2-bit `granted` index, pops the granted channel and registers the flit onto a single valid/ready output toward the mesh output port.
- One instance sits per router output port, in front of that port's arbiter.

Parameters:
FLIT_W, 64, flit width in bits
DEPTH, 2, entries per input-channel FIFO (power of two, >=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  4  per-channel flit valid, bit i = channel i
in_flit  input  4*FLIT_W  channel i flit at bits [i*FLIT_W +: FLIT_W]
in_ready  output  4  per-channel space available
requests  output  4  to arbiter; bit i = channel i FIFO non-empty
granted  input  2  from arbiter; index of winning channel
out_valid  output  1  registered output flit valid
out_flit  output  FLIT_W  registered output flit
out_src  output  2  channel index the current output flit came from
out_ready  input  1  downstream accepts out_flit this cycle

Behaviour:
- Reset (async assert, sync release):
  - All FIFO counts, read pointers and write pointers = 0.
  - requests = 4'b0000, in_ready = 4'b1111.
  - out_valid = 0, out_flit = 0, out_src = 2'd0.
- Per-channel FIFO:
  - Push when in_valid[i] & in_ready[i].
  - in_ready[i] = (count_i < DEPTH), driven from registered state only. There is no combinational path from out_ready, granted or in_valid.
  - A full channel therefore deasserts in_ready even if it pops that cycle.
- requests[i] = (count_i != 0), purely from registered count.
- Grant qualification:
  - grant_ok = requests[granted].
  - The arbiter's output is don't-care when requests == 0. The block must ignore `granted` when grant_ok = 0.
- Output stage:
  - load = grant_ok & (~out_valid | out_ready).
  - On load: pop the head of channel `granted`. Next cycle out_flit = that head, out_src = granted, out_valid = 1.
  - If out_valid & out_ready & ~load: out_valid <= 0. out_flit and out_src hold their last values.
  - If out_valid & ~out_ready: out_valid, out_flit and out_src hold. No pop occurs.
- Latency: a flit pushed in cycle N is at the FIFO head in N+1. requests[i] rises in N+1. With the output free, the flit appears on out_valid in N+2.
- Throughput: one flit per cycle while out_ready = 1 and any request is pending.
- Simultaneous push and pop on the same channel: count unchanged, pointers both advance.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Ordering within a channel is strictly FIFO.
- Only one channel pops per cycle, always the one selected by `granted`. Fairness and priority are the arbiter's responsibility.
- Reset mid-operation:
  - All buffered flits and the output flit are discarded immediately.
  - out_valid drops asynchronously and requests drops to 0.
- Overflow/underflow:
  - A push to a full channel is blocked by in_ready. Data offered with in_ready = 0 is not captured.
  - A pop of an empty channel is impossible by grant qualification.

Test Plan:
1. Reset then idle.
   - Hold reset 1 cycle with in_valid = 0 -> requests = 0000, in_ready = 1111, out_valid = 0, out_flit = 0.
   - Drive granted = 2'd3 with no requests -> no pop, out_valid stays 0.
2. Single flit, channel 2.
   - Push 64'hA5A5 on channel 2 in cycle N, out_ready = 1, stub arbiter grants 2 -> requests = 0100 at N+1.
   - out_valid = 1, out_flit = 64'hA5A5, out_src = 2 at N+2.
   - requests = 0000 at N+2.
3. Fill and backpressure.
   - Push 3 flits on channel 0 with out_ready = 0 and the grant held at 0.
   - First flit loads the output; the next two fill the FIFO and in_ready[0] = 0.
   - Raise out_ready -> flits emerge in push order on consecutive cycles, and in_ready[0] returns to 1.
4. All four channels.
   - Preload one flit per channel (values 1..4), connect the real four_way_arbiter, out_ready = 1.
   - Output shows 4 flits on 4 consecutive cycles, each with out_src matching the channel its value was pushed on.
   - requests drops to 0000 after the last pop.
5. Output stall.
   - out_valid = 1 with out_ready = 0 for 3 cycles -> out_flit, out_src and all FIFO counts stay constant.
6. Reset mid-stream.
   - Assert reset while out_valid = 1 and channels 1 and 3 each hold 2 flits.
   - out_valid = 0 and requests = 0000 immediately, without waiting for a clock edge.
   - After release, the first pushed flit is the first one out.
